// File: rtl/qam_frame_sched_if.sv
// Handshake bundle between the frame scheduler, its payload source and the modulator.
// The master modport is the scheduler side; slave is the source/modulator/controller side.
interface qam_frame_sched_if;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       src_valid;
  logic [3:0] src_data;
  logic       src_ready;
  logic       mod_valid;
  logic [3:0] mod_data;
  logic       mod_ready;
  logic [1:0] sym_type;

  modport master (
    input  start, src_valid, src_data, mod_ready,
    output busy, frame_done, src_ready, mod_valid, mod_data, sym_type
  );

  modport slave (
    output start, src_valid, src_data, mod_ready,
    input  busy, frame_done, src_ready, mod_valid, mod_data, sym_type
  );
endinterface

// File: rtl/qam_frame_sched.sv
// Frame scheduler for a 16-QAM modulator: preamble, payload with periodic pilots, then an idle gap.
// All symbols leave through a single output register with a valid/ready handshake.
//
// state    | meaning
// IDLE     | waiting for start
// PREAMBLE | emitting alternating 0/F training symbols
// PAYLOAD  | forwarding source symbols
// PILOT    | emitting one pilot symbol, then back to PAYLOAD
// GAP      | idle spacing before the next start is accepted
module qam_frame_sched #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned PAYLOAD_LEN  = 64,
  parameter int unsigned PILOT_PERIOD = 16,
  parameter logic [3:0]  PILOT_SYM    = 4'hF,
  parameter int unsigned GAP_LEN      = 4
) (
  input logic               axi_clk,
  input logic               axi_rstn,
  qam_frame_sched_if.master bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PILOT, GAP} state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [11:0] PAY_LEN  = 12'(PAYLOAD_LEN);
  localparam logic [11:0] PIL_PER  = 12'(PILOT_PERIOD);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_LEN - 1);

  state_t      state;
  logic [7:0]  pre_cnt;
  logic [11:0] pay_cnt;
  logic [11:0] pil_left;
  logic [7:0]  gap_cnt;
  logic        mod_valid_q;
  logic [3:0]  mod_data_q;
  logic [1:0]  sym_type_q;
  logic        busy_q;
  logic        frame_done_q;

  logic        loadable;
  logic        xfer;
  logic        src_hs;
  logic        src_ready_c;
  logic [11:0] pay_next;

  assign xfer        = mod_valid_q && bus.mod_ready;
  assign loadable    = !mod_valid_q || bus.mod_ready;
  // Stop accepting once the last payload symbol is held, so the frame cannot overrun.
  assign src_ready_c = (state == PAYLOAD) && loadable && (pay_cnt != PAY_LEN);
  assign src_hs      = src_ready_c && bus.src_valid;
  assign pay_next    = pay_cnt + 12'd1;

  assign bus.src_ready  = src_ready_c;
  assign bus.mod_valid  = mod_valid_q;
  assign bus.mod_data   = mod_data_q;
  assign bus.sym_type   = sym_type_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state        <= IDLE;
      pre_cnt      <= 8'd0;
      pay_cnt      <= 12'd0;
      pil_left     <= 12'd0;
      gap_cnt      <= 8'd0;
      mod_valid_q  <= 1'b0;
      mod_data_q   <= 4'h0;
      sym_type_q   <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (xfer) mod_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= PREAMBLE;
            pre_cnt <= 8'd0;
            busy_q  <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (loadable) begin
            mod_valid_q <= 1'b1;
            mod_data_q  <= pre_cnt[0] ? 4'hF : 4'h0;
            sym_type_q  <= 2'd0;
            if (pre_cnt == PRE_LAST) begin
              state    <= PAYLOAD;
              pay_cnt  <= 12'd0;
              pil_left <= PIL_PER;
            end else begin
              pre_cnt <= pre_cnt + 8'd1;
            end
          end
        end
        PAYLOAD: begin
          if (src_hs) begin
            mod_valid_q <= 1'b1;
            mod_data_q  <= bus.src_data;
            sym_type_q  <= 2'd2;
            pay_cnt     <= pay_next;
            // Pilot down-counter: terminal count marks a pilot slot unless the frame just ended.
            if (pil_left == 12'd1) begin
              pil_left <= PIL_PER;
              if (pay_next != PAY_LEN) state <= PILOT;
            end else begin
              pil_left <= pil_left - 12'd1;
            end
          end else if ((pay_cnt == PAY_LEN) && xfer) begin
            frame_done_q <= 1'b1;
            state        <= GAP;
            gap_cnt      <= GAP_LAST;
          end
        end
        PILOT: begin
          if (loadable) begin
            mod_valid_q <= 1'b1;
            mod_data_q  <= PILOT_SYM;
            sym_type_q  <= 2'd1;
            state       <= PAYLOAD;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/qam_frame_sched.md
QAM_FRAME_SCHED -- requirements
Module: qam_frame_sched

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8, number of preamble symbols per frame (range 1..255).
REQ-002 SHALL have parameter PAYLOAD_LEN, default 64, number of payload symbols per frame (range 1..4095).
REQ-003 SHALL have parameter PILOT_PERIOD, default 16, payload symbols between pilot insertions (range 1..4095).
REQ-004 SHALL have parameter PILOT_SYM, default 4'hF, 4-bit pilot symbol value.
REQ-005 SHALL have parameter GAP_LEN, default 4, idle cycles after a frame before a new start is accepted (range 1..255).
REQ-006 SHALL have port axi_clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port axi_rstn, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, single-cycle frame request.
REQ-009 SHALL have port busy, output, 1, high from start acceptance until GAP completes.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse on final payload-symbol handshake.
REQ-011 SHALL have port src_valid, input, 1, payload source valid.
REQ-012 SHALL have port src_data, input, 4, payload 16-QAM symbol.
REQ-013 SHALL have port src_ready, output, 1, payload source ready.
REQ-014 SHALL have port mod_valid, output, 1, symbol valid toward the modulator (qam_mod_top din_valid).
REQ-015 SHALL have port mod_data, output, 4, symbol toward the modulator (din).
REQ-016 SHALL have port mod_ready, input, 1, modulator ready (din_ready).
REQ-017 SHALL have port sym_type, output, 2, qualifies mod_data: 0 preamble, 1 pilot, 2 payload, 3 unused.

Function
REQ-018 SHALL implement FSM states IDLE, PREAMBLE, PAYLOAD, PILOT, GAP.
REQ-019 IDLE -> PREAMBLE SHALL occur on the cycle after start is sampled high in IDLE; start in any other state SHALL be ignored (no queuing).
REQ-020 mod_valid/mod_data/sym_type SHALL come from one output register; a transfer occurs when mod_valid and mod_ready are both high; once asserted, mod_valid, mod_data and sym_type SHALL stay stable until the transfer.
REQ-021 The output register SHALL load a new symbol when it is empty or its current symbol transfers in that cycle, giving full throughput (one symbol per cycle) when mod_ready is held high.
REQ-022 PREAMBLE: symbol k (0-based) SHALL be 4'h0 for even k and 4'hF for odd k, with sym_type 0; after PREAMBLE_LEN transfers the FSM SHALL enter PAYLOAD.
REQ-023 PAYLOAD: src_ready SHALL equal (state==PAYLOAD) AND output register loadable AND no pilot pending; src_data SHALL be forwarded unchanged with sym_type 2, one cycle of latency from src handshake to mod_valid.
REQ-024 A 12-bit payload counter SHALL count src handshakes; when the count is a nonzero multiple of PILOT_PERIOD and is less than PAYLOAD_LEN, the FSM SHALL enter PILOT and emit exactly one PILOT_SYM with sym_type 1, then return to PAYLOAD.
REQ-025 No pilot SHALL follow the final payload symbol; the default frame is 8 preamble + 64 payload + 3 pilots (after payload symbols 16, 32, 48) = 75 transfers.
REQ-026 Source underflow (src_valid low in PAYLOAD) SHALL produce bubbles (mod_valid low once the register drains); there SHALL be no timeout.
REQ-027 frame_done SHALL pulse the cycle after the PAYLOAD_LEN-th mod transfer; the FSM SHALL then enter GAP.
REQ-028 GAP SHALL last GAP_LEN cycles with mod_valid low and src_ready low, then enter IDLE; busy SHALL drop on IDLE entry.
REQ-029 Modulator backpressure (mod_ready low) SHALL never drop, duplicate or reorder symbols, including during the PREAMBLE->PAYLOAD, PAYLOAD->PILOT and PILOT->PAYLOAD transitions.
REQ-030 Counters SHALL clear on entry to their state and SHALL not wrap within a frame.

Reset
REQ-031 While axi_rstn is low: state IDLE, all counters 0, mod_valid 0, mod_data 4'h0, sym_type 0, src_ready 0, busy 0, frame_done 0.
REQ-032 Reset mid-frame SHALL abort the frame immediately with no further symbols; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Defaults, mod_ready=1, src_valid=1 with incrementing data -> 75 consecutive transfers: 0,F,0,F,0,F,0,F, payload, F pilots after payload 16/32/48; frame_done at transfer 75; busy low 4 cycles later.
REQ-034 Random mod_ready (50%) -> same 75-symbol sequence, with mod_data held stable during every stall.
REQ-035 src_valid low for 10 cycles mid-payload -> mod_valid low during the gap, no lost or extra symbols, pilot positions unchanged.
REQ-036 start pulsed during PAYLOAD and during GAP -> ignored; start in IDLE -> preamble begins the next cycle.
REQ-037 axi_rstn low at payload symbol 30 -> all outputs at reset values asynchronously; after release plus start, a full correct frame is produced.
REQ-038 PILOT_PERIOD=64, PAYLOAD_LEN=64 -> zero pilots, 72 transfers.
